// File: rtl/full_adder_assign.sv
// full_adder_assign: WIDTH-bit ripple-carry full adder.
// The combinational sum/carry/overflow path has zero latency and is meant for
// bit-slice use. A registered copy with a valid flag serves pipelined datapaths.
// Optional feature macro: FULL_ADDER_ASSIGN_STATS_EN adds a saturating 16-bit
// count of captured operations that produced a carry out, plus a synchronous
// clear input for that count.
module full_adder_assign #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    input  logic             in_valid,
`ifdef FULL_ADDER_ASSIGN_STATS_EN
    input  logic             clr_stats,
    output logic [15:0]      carry_count,
`endif
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow,
    output logic [WIDTH-1:0] sum_q,
    output logic             carry_out_q,
    output logic             overflow_q,
    output logic             out_valid
);

    // carry_chain[i] is the carry into bit i; carry_chain[WIDTH] leaves the MSB.
    logic [WIDTH:0]   carry_chain;
    logic [WIDTH-1:0] propagate;

    assign carry_chain[0] = carry_in;

    // One full-adder cell per bit, chained through carry_chain.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign propagate[gi]       = a[gi] ^ b[gi];
            assign sum[gi]             = propagate[gi] ^ carry_chain[gi];
            assign carry_chain[gi + 1] = (a[gi] & b[gi]) | (carry_chain[gi] & propagate[gi]);
        end
    endgenerate

    assign carry_out = carry_chain[WIDTH];
    // Signed overflow: carry into the MSB disagrees with carry out of it.
    // For WIDTH=1 the carry into the MSB is carry_in itself.
    assign overflow  = carry_chain[WIDTH] ^ carry_chain[WIDTH-1];

    // Registered copy of the result.
    logic [WIDTH-1:0] sum_reg;
    logic             carry_out_reg;
    logic             overflow_reg;
    logic             valid_reg;

    // Capture the combinational result on in_valid; otherwise hold the data
    // and drop the valid flag. Reset clears everything immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_reg       <= '0;
            carry_out_reg <= 1'b0;
            overflow_reg  <= 1'b0;
            valid_reg     <= 1'b0;
        end else begin
            valid_reg <= in_valid;
            if (in_valid) begin
                sum_reg       <= sum;
                carry_out_reg <= carry_out;
                overflow_reg  <= overflow;
            end
        end
    end

    assign sum_q       = sum_reg;
    assign carry_out_q = carry_out_reg;
    assign overflow_q  = overflow_reg;
    assign out_valid   = valid_reg;

`ifdef FULL_ADDER_ASSIGN_STATS_EN
    localparam logic [15:0] COUNT_MAX = 16'hFFFF;

    logic [15:0] count_reg;
    logic [15:0] count_next;

    // Next count: clear wins over increment; increment stops at COUNT_MAX.
    always_comb begin
        count_next = count_reg;
        if (clr_stats) begin
            count_next = '0;
        end else if (in_valid && carry_out && (count_reg != COUNT_MAX)) begin
            count_next = count_reg + 16'd1;
        end
    end

    // Count register, asynchronously cleared with the rest of the datapath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign carry_count = count_reg;
`endif

endmodule

// File: tb/tb_full_adder_assign.sv
// Testbench for full_adder_assign: a WIDTH=1 instance for the exhaustive
// truth table and a WIDTH=8 instance for directed, random and registered-path
// checks. Expected registered results go into a queue; a monitor pops them
// whenever out_valid is seen.
module tb_full_adder_assign;

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    // WIDTH=1 instance signals
    logic [0:0] a1, b1, sum1, sum_q1;
    logic       ci1, co1, ov1, co_q1, ov_q1, ov_valid1;

    // WIDTH=8 instance signals
    logic [7:0] a8, b8, sum8, sum_q8;
    logic       ci8, iv8, co8, ov8, co_q8, ov_q8, out_valid8;
`ifdef FULL_ADDER_ASSIGN_STATS_EN
    logic        clr_stats = 1'b0;
    logic [15:0] carry_count;
    logic        clr_stats1 = 1'b0;
    logic [15:0] carry_count1;
`endif

    full_adder_assign #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .carry_in(ci1), .in_valid(1'b0),
`ifdef FULL_ADDER_ASSIGN_STATS_EN
        .clr_stats(clr_stats1), .carry_count(carry_count1),
`endif
        .sum(sum1), .carry_out(co1), .overflow(ov1),
        .sum_q(sum_q1), .carry_out_q(co_q1), .overflow_q(ov_q1), .out_valid(ov_valid1)
    );

    full_adder_assign #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .carry_in(ci8), .in_valid(iv8),
`ifdef FULL_ADDER_ASSIGN_STATS_EN
        .clr_stats(clr_stats), .carry_count(carry_count),
`endif
        .sum(sum8), .carry_out(co8), .overflow(ov8),
        .sum_q(sum_q8), .carry_out_q(co_q8), .overflow_q(ov_q8), .out_valid(out_valid8)
    );

    int compared = 0;
    int mismatched = 0;

    typedef struct {
        logic [7:0] s;
        logic       co;
        logic       ov;
    } exp_t;

    exp_t exp_q[$];
    exp_t held = '{s: 8'h00, co: 1'b0, ov: 1'b0};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer addition; overflow from the signed range.
    function automatic void ref_add(input int w, input int unsigned x, input int unsigned y,
                                    input int unsigned ci, output int unsigned s,
                                    output int unsigned co, output int unsigned ov);
        int unsigned total;
        int sx, sy, sv, lim;
        total = x + y + ci;
        lim   = 1 << (w - 1);
        s     = total % (1 << w);
        co    = total >> w;
        sx    = (x >= lim) ? int'(x) - 2 * lim : int'(x);
        sy    = (y >= lim) ? int'(y) - 2 * lim : int'(y);
        sv    = sx + sy + int'(ci);
        ov    = (sv >= lim || sv < -lim) ? 1 : 0;
    endfunction

    // Drive the 8-bit instance, queue the expected capture, check combinational outputs.
    task automatic drive8(input logic [7:0] x, input logic [7:0] y, input logic ci, input logic v);
        int unsigned s, co, ov;
        exp_t e;
        a8 = x; b8 = y; ci8 = ci; iv8 = v;
        ref_add(8, int'(x), int'(y), int'(ci), s, co, ov);
        e.s = s[7:0]; e.co = co[0]; e.ov = ov[0];
        if (v) exp_q.push_back(e);
        #1;
        $display("op a=%02h b=%02h ci=%0d v=%0d -> sum=%02h co=%0d ov=%0d", x, y, ci, v, sum8, co8, ov8);
        check("comb_sum", 32'(sum8), s);
        check("comb_carry", 32'(co8), co);
        check("comb_overflow", 32'(ov8), ov);
    endtask

    // Monitor: pop on out_valid; otherwise the registers must hold the last capture.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (out_valid8) begin
                if (exp_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL spurious_valid: got out_valid=1 expected no pending capture");
                end else begin
                    e = exp_q.pop_front();
                    held = e;
                    check("reg_sum", 32'(sum_q8), 32'(e.s));
                    check("reg_carry", 32'(co_q8), 32'(e.co));
                    check("reg_overflow", 32'(ov_q8), 32'(e.ov));
                end
            end else begin
                check("hold_sum", 32'(sum_q8), 32'(held.s));
                check("hold_carry", 32'(co_q8), 32'(held.co));
            end
        end
    end

    // Asynchronous reset discards the registered state and anything in flight.
    always @(negedge rst_n) begin
        exp_q.delete();
        held = '{s: 8'h00, co: 1'b0, ov: 1'b0};
    end

    logic [1:0] w1_table [8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

    initial begin
        int unsigned s, co, ov;
        logic [2:0] idx;
        a1 = '0; b1 = '0; ci1 = 1'b0;
        a8 = '0; b8 = '0; ci8 = 1'b0; iv8 = 1'b0;

        // Reset asserted asynchronously before any clock edge.
        #1 rst_n = 1'b0;
        #1;
        check("reset_sum_q", 32'(sum_q8), 32'h0);
        check("reset_carry_q", 32'(co_q8), 32'h0);
        check("reset_overflow_q", 32'(ov_q8), 32'h0);
        check("reset_out_valid", 32'(out_valid8), 32'h0);

        // WIDTH=1 exhaustive truth table, 100ns apart.
        for (int i = 0; i < 8; i++) begin
            idx = 3'(i);
            a1 = idx[1]; b1 = idx[0]; ci1 = idx[2];
            #100;
            ref_add(1, int'(a1), int'(b1), int'(ci1), s, co, ov);
            $display("w1 a=%0d b=%0d ci=%0d -> co=%0d sum=%0d ov=%0d", a1, b1, ci1, co1, sum1, ov1);
            check("w1_carry_sum", 32'({co1, sum1}), 32'(w1_table[i]));
            check("w1_overflow", 32'(ov1), ov);
        end

        @(negedge clk) rst_n = 1'b1;

        // Directed boundary cases.
        @(negedge clk) drive8(8'hFF, 8'h00, 1'b1, 1'b0);
        check("ff_plus_cin_sum", 32'(sum8), 32'h00);
        check("ff_plus_cin_carry", 32'(co8), 32'h1);
        @(negedge clk) drive8(8'h7F, 8'h01, 1'b0, 1'b0);
        check("7f_plus_1_ovf", 32'(ov8), 32'h1);

        // Registered capture then hold.
        @(negedge clk) drive8(8'h12, 8'h34, 1'b0, 1'b1);
        @(negedge clk) drive8(8'h00, 8'h00, 1'b0, 1'b0);
        check("capture_46", 32'(sum_q8), 32'h46);
        @(negedge clk) drive8(8'hAA, 8'h55, 1'b1, 1'b0);
        check("hold_46", 32'(sum_q8), 32'h46);

        // Random stimulus.
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            drive8(8'($urandom), 8'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0));
        end

        // Mid-stream asynchronous reset while out_valid is high.
        @(negedge clk) drive8(8'hC3, 8'h5A, 1'b1, 1'b1);
        @(negedge clk) drive8(8'h00, 8'h00, 1'b0, 1'b0);
        #2;
        check("pre_reset_valid", 32'(out_valid8), 32'h1);
        rst_n = 1'b0;
        #1;
        check("async_sum_q", 32'(sum_q8), 32'h0);
        check("async_carry_q", 32'(co_q8), 32'h0);
        check("async_overflow_q", 32'(ov_q8), 32'h0);
        check("async_out_valid", 32'(out_valid8), 32'h0);
        @(negedge clk) rst_n = 1'b1;

`ifdef FULL_ADDER_ASSIGN_STATS_EN
        @(negedge clk) clr_stats = 1'b1;
        @(negedge clk) clr_stats = 1'b0;
        check("stats_cleared", 32'(carry_count), 32'h0);
        drive8(8'hFF, 8'h01, 1'b0, 1'b1);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            check("stats_count", 32'(carry_count), 32'(k));
            if (k < 3) drive8(8'hFF, 8'h01, 1'b0, 1'b1);
            else begin
                clr_stats = 1'b1;
                drive8(8'hFF, 8'h01, 1'b0, 1'b1);
            end
        end
        @(negedge clk) clr_stats = 1'b0;
        check("stats_clear_priority", 32'(carry_count), 32'h0);
`endif

        @(negedge clk) drive8(8'h00, 8'h00, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
